// File: rtl/dlprv32_seq_pkg.sv
// Shared definitions for the five-stage pipe sequencer: stage indices,
// FSM state encoding, the PC increment, and a stage-to-chip-select helper.
// Pure declarations; no timing or flow control.
package dlprv32_seq_pkg;

  typedef enum logic [2:0] {
    ST_F = 3'd0,
    ST_D = 3'd1,
    ST_E = 3'd2,
    ST_M = 3'd3,
    ST_W = 3'd4
  } stage_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_ADVANCE = 3'd4,
    S_HALT    = 3'd5
  } state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // One-hot chip-select bit for a stage index.
  function automatic logic [4:0] stage_onehot(input stage_e s);
    return 5'b00001 << s;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-state watchdog: counts cycles while enabled, restarts on clear.
// expire_o is combinational from the count: high on the TIMEOUT-th counted cycle.
// No flow control; the owner decides what an expiry means.
module seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = cnt_en_i && (cnt_q == CW'(TIMEOUT - 1));

  // Next count: restart on clear, otherwise count while enabled and not yet expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_en_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pipe_sequencer.sv
// Five-stage instruction sequencer: issues one-hot chip-selects F..W and handshakes each stage's rdy.
// Latency: min 4 cycles per stage (ISSUE, WAIT_LO, WAIT_HI, ADVANCE); all outputs registered.
// Backpressure: waits unbounded on rdy; with SEQ_TIMEOUT_EN a stuck wait halts with sticky err.
module pipe_sequencer
  import dlprv32_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [4:0]  cs_stage,
  input  logic [4:0]  rdy_stage,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [2:0]  stage,
  output logic [31:0] instret,
  output logic        busy,
  output logic        err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("pipe_sequencer: TIMEOUT must be at least 1");
  end

  state_e      state_q, state_d;
  stage_e      stage_q, stage_d;
  logic [4:0]  cs_q, cs_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        redir_q, redir_d;
  logic [29:0] tgt_q, tgt_d;
  logic        wd_expire;

  // Redirect targets are word aligned; the low address bits are dropped.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^branch_target[1:0];

`ifdef SEQ_TIMEOUT_EN
  logic in_wait;
  assign in_wait = (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_d != state_q),
    .cnt_en_i (in_wait),
    .expire_o (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  // Next-state and registered-output computation for the handshake FSM.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    err_d     = err_q;
    redir_d   = redir_q;
    tgt_d     = tgt_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_ISSUE;
          stage_d = ST_F;
        end
      end
      S_ISSUE: state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!rdy_stage[stage_q]) begin
          state_d = S_WAIT_HI;
        end else if (wd_expire) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (branch_taken && (stage_q == ST_E)) begin
          redir_d = 1'b1;
          tgt_d   = branch_target[31:2];
        end
        if (rdy_stage[stage_q]) begin
          state_d = S_ADVANCE;
        end else if (wd_expire) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_ADVANCE: begin
        if (stage_q == ST_W) begin
          pc_d      = redir_q ? {tgt_q, 2'b00} : pc_q + PC_STEP;
          redir_d   = 1'b0;
          instret_d = instret_q + 32'd1;
          stage_d   = ST_F;
          state_d   = en ? S_ISSUE : S_IDLE;
        end else begin
          stage_d = stage_e'(stage_q + 3'd1);
          state_d = S_ISSUE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    cs_d   = (state_d == S_ISSUE) ? stage_onehot(stage_d) : 5'b0;
    busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      stage_q   <= ST_F;
      cs_q      <= 5'b0;
      pc_q      <= RESET_PC;
      instret_q <= 32'd0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      redir_q   <= 1'b0;
      tgt_q     <= 30'd0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      cs_q      <= cs_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      redir_q   <= redir_d;
      tgt_q     <= tgt_d;
    end
  end

  assign cs_stage = cs_q;
  assign pc       = pc_q;
  assign stage    = stage_q;
  assign instret  = instret_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer with a responsive per-stage rdy model.
// A second instance with RESET_PC=FFFF_FFFC runs in lockstep to cover PC wrap.
// SEQ_TIMEOUT_EN adds the watchdog halt scenario.
module tb_pipe_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [4:0]  rdy_stage = 5'b11111;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [4:0]  cs_stage, cs_w;
  logic [31:0] pc, pc_w, instret, instret_w;
  logic [2:0]  stage, stage_w;
  logic        busy, busy_w, err, err_w;

  logic [4:0]  drop_mask = 5'b11111;
  logic [4:0]  cs_log[$];
  int          vec = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  pipe_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cs_stage(cs_stage), .rdy_stage(rdy_stage),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .stage(stage), .instret(instret), .busy(busy), .err(err)
  );

  pipe_sequencer #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(8)) dut_w (
    .clk(clk), .rst(rst), .en(en), .cs_stage(cs_w), .rdy_stage(rdy_stage),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc_w), .stage(stage_w), .instret(instret_w), .busy(busy_w), .err(err_w)
  );

  // Stage model: drop rdy one cycle after cs, raise it one cycle later.
  initial begin
    logic [4:0] pend;
    forever begin
      @(posedge clk); #1;
      if (cs_stage != 5'b0) begin
        pend = cs_stage & drop_mask;
        @(posedge clk); #1;
        rdy_stage = rdy_stage & ~pend;
        @(posedge clk); #1;
        rdy_stage = rdy_stage | pend;
      end
    end
  end

  // Chip-select order recorder.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (cs_stage != 5'b0) cs_log.push_back(cs_stage);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; branch_taken = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    vec++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle busy got %b want 0", name, busy); end
  endtask

  task automatic test_reset();
    do_reset();
    vec++; if (cs_stage !== 5'b0) begin bad++; $display("FAIL reset_cs got %h want 00", cs_stage); end
    vec++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got %h want 00000000", pc); end
    vec++; if (pc_w !== 32'hFFFF_FFFC) begin bad++; $display("FAIL reset_pc_w got %h want fffffffc", pc_w); end
    vec++; if (stage !== 3'd0) begin bad++; $display("FAIL reset_stage got %0d want 0", stage); end
    vec++; if (instret !== 32'd0) begin bad++; $display("FAIL reset_instret got %0d want 0", instret); end
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic ok;
    logic [4:0] exp_cs;
    cs_log.delete();
    en = 1'b1;
    while (instret == 32'd0 && n < 100) begin tick(); n++; end
    en = 1'b0;
    vec++; if (n !== 21) begin bad++; $display("FAIL first_retire_cycles got %0d want 21", n); end
    vec++; if (pc !== 32'd4) begin bad++; $display("FAIL first_pc got %h want 00000004", pc); end
    vec++; if (pc_w !== 32'd0) begin bad++; $display("FAIL wrap_pc got %h want 00000000", pc_w); end
    vec++; if (instret !== 32'd1) begin bad++; $display("FAIL first_instret got %0d want 1", instret); end
    wait_idle("b2b");
    ok = (cs_log.size() == 10);
    for (int i = 0; i < cs_log.size() && i < 10; i++) begin
      exp_cs = 5'b00001 << (i % 5);
      if (cs_log[i] !== exp_cs) ok = 1'b0;
    end
    vec++; if (ok !== 1'b1) begin bad++; $display("FAIL cs_order got %0d pulses, order ok=%b want 10 pulses F,D,E,M,W x2", cs_log.size(), ok); end
    vec++; if (pc !== 32'd8) begin bad++; $display("FAIL b2b_pc got %h want 00000008", pc); end
    vec++; if (instret !== 32'd2) begin bad++; $display("FAIL b2b_instret got %0d want 2", instret); end
    vec++; if (stage !== 3'd0) begin bad++; $display("FAIL b2b_stage got %0d want 0", stage); end
  endtask

  task automatic test_branch();
    int n = 0;
    en = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0200;
    tick();
    en = 1'b0;
    while (busy && n < 200) begin
      branch_target = (stage == 3'd2) ? 32'h0000_0103 : 32'h0000_0200;
      tick(); n++;
    end
    branch_taken = 1'b0;
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL branch_idle busy got %b want 0", busy); end
    vec++; if (pc !== 32'h0000_0100) begin bad++; $display("FAIL branch_pc got %h want 00000100", pc); end
    vec++; if (pc_w !== 32'h0000_0100) begin bad++; $display("FAIL branch_pc_w got %h want 00000100", pc_w); end
    vec++; if (instret !== 32'd3) begin bad++; $display("FAIL branch_instret got %0d want 3", instret); end
    // Following instruction must fall through: the redirect is consumed.
    en = 1'b1; tick(); en = 1'b0;
    wait_idle("nobranch");
    vec++; if (pc !== 32'h0000_0104) begin bad++; $display("FAIL redir_clear_pc got %h want 00000104", pc); end
  endtask

  task automatic test_en_drop();
    int n = 0;
    cs_log.delete();
    en = 1'b1;
    while (stage != 3'd1 && n < 100) begin tick(); n++; end
    en = 1'b0;
    vec++; if (stage !== 3'd1) begin bad++; $display("FAIL en_drop_reach_d got %0d want 1", stage); end
    wait_idle("en_drop");
    vec++; if (pc !== 32'h0000_0108) begin bad++; $display("FAIL en_drop_pc got %h want 00000108", pc); end
    vec++; if (instret !== 32'd5) begin bad++; $display("FAIL en_drop_instret got %0d want 5", instret); end
    vec++; if (cs_log.size() !== 5) begin bad++; $display("FAIL en_drop_pulses got %0d want 5", cs_log.size()); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    en = 1'b1; tick(); en = 1'b0;
    while (cs_stage != 5'b01000 && n < 100) begin tick(); n++; end
    vec++; if (cs_stage !== 5'b01000) begin bad++; $display("FAIL mid_reach_m got %h want 08", cs_stage); end
    tick();  // WAIT_LO of M
    tick();  // WAIT_HI of M
    rst = 1'b1; en = 1'b1; branch_taken = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0; branch_taken = 1'b0;
    vec++; if (cs_stage !== 5'b0) begin bad++; $display("FAIL mid_cs got %h want 00", cs_stage); end
    vec++; if (pc !== 32'h0) begin bad++; $display("FAIL mid_pc got %h want 00000000", pc); end
    vec++; if (pc_w !== 32'hFFFF_FFFC) begin bad++; $display("FAIL mid_pc_w got %h want fffffffc", pc_w); end
    vec++; if (stage !== 3'd0) begin bad++; $display("FAIL mid_stage got %0d want 0", stage); end
    vec++; if (instret !== 32'd0) begin bad++; $display("FAIL mid_instret got %0d want 0", instret); end
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got %b want 0", busy); end
    tick();
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_stays_idle busy got %b want 0", busy); end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    do_reset();
    drop_mask = 5'b11011;
    en = 1'b1; tick(); en = 1'b0;
    while (cs_stage != 5'b00100 && n < 100) begin tick(); n++; end
    tick();  // first WAIT_LO cycle of E
    n = 0;
    while (!err && n < 50) begin tick(); n++; end
    vec++; if (n !== 8) begin bad++; $display("FAIL timeout_cycles got %0d want 8", n); end
    vec++; if (err !== 1'b1) begin bad++; $display("FAIL timeout_err got %b want 1", err); end
    vec++; if (cs_stage !== 5'b0) begin bad++; $display("FAIL timeout_cs got %h want 00", cs_stage); end
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got %b want 0", busy); end
    drop_mask = 5'b11111;
    en = 1'b1; tick(); tick(); tick();
    vec++; if (err !== 1'b1 || cs_stage !== 5'b0) begin bad++; $display("FAIL halt_sticky err=%b cs=%h want 1 00", err, cs_stage); end
    do_reset();
    vec++; if (err !== 1'b0) begin bad++; $display("FAIL timeout_rst_err got %b want 0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_branch();
    test_en_drop();
    test_reset_mid();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
